dcache_sa_wb: RTL and testbench
===============================

# dcache_sa_wb

Parametrised N-way set-associative, write-back, write-allocate data cache for the MEM stage of the pipelined RV32I core. Hits are served combinationally with no stall. Misses are handled by an internal FSM over a simple request/acknowledge memory port, with dirty-victim writeback and refill, while `stall_o` holds the pipeline. Tree pseudo-LRU replacement and saturating hit/miss counters are included.

## Interface
- `ADDRESS_WIDTH`, 32, byte address width
- `DATA_WIDTH`, 32, word/line width (one word per line)
- `SET_BITS`, 8, log2 of number of sets
- `WAYS`, 2, associativity; legal values 1, 2, 4
- `CNT_WIDTH`, 32, perf counter width
- `clk_i` in 1: clock, rising edge
- `rst_ni` in 1: asynchronous, active-low reset
- `MemWriteM_i` in 1: store request
- `ResultSrcM_i` in 2: load request when 2'b01
- `be_i` in DATA_WIDTH/8: store byte enables
- `addr_i` in ADDRESS_WIDTH: byte address; bits [1:0] ignored
- `data_i` in DATA_WIDTH: store data
- `data_o` out DATA_WIDTH: load data
- `stall_o` out 1: hold the pipeline
- `mem_req_o` out 1: memory request valid
- `mem_we_o` out 1: 1 = writeback, 0 = refill read
- `mem_addr_o` out ADDRESS_WIDTH: word-aligned memory address
- `mem_wdata_o` out DATA_WIDTH: writeback data
- `mem_rdata_i` in DATA_WIDTH: refill data, valid with ack
- `mem_ack_i` in 1: completes the current request
- `hit_count_o`, `miss_count_o` out CNT_WIDTH: saturating counters

## Operation
- Address split: tag = addr[ADDRESS_WIDTH-1 : SET_BITS+2]; set = addr[SET_BITS+1 : 2].
- Per line: valid, dirty, tag, data. Per set: WAYS-1 PLRU bits.
- An access is active when the store or load request is high. If both are high, the access is a store.
- Hit: any valid way with a matching tag. At most one way may match (the design invariant).
- Load hit: `data_o` = the hit way's data; PLRU is updated to point away from that way.
- Store hit: bytes with `be_i` set are merged into the line; dirty is set to 1; PLRU is updated.
- `data_o` is 0 whenever the access is not a load hit.
- Miss: `stall_o` = 1 in the same cycle, and the FSM leaves IDLE.
- Victim selection: the lowest-index invalid way; if all ways are valid, the PLRU way. The victim is latched on the miss cycle.
- FSM states:
  - IDLE → WB if the victim is valid and dirty, else → REFILL.
  - WB: `mem_req_o` = 1, `mem_we_o` = 1, address = {victim tag, set, 2'b00}, data = victim data. Held until `mem_ack_i`, then → REFILL.
  - REFILL: `mem_req_o` = 1, `mem_we_o` = 0, address = {tag, set, 2'b00}. On `mem_ack_i`, the victim line is written with valid = 1, dirty = 0, data = `mem_rdata_i`; then → IDLE.
  - Back in IDLE, the access is re-evaluated. It now hits and completes as a normal hit, including the store merge and counting.
- Requests are not withdrawn: once `mem_req_o` rises, address and data stay stable until ack.
- Counters:
  - `hit_count_o` increments on each completing hit cycle.
  - `miss_count_o` increments once per miss, on IDLE exit.
  - Both saturate at all-ones and do not wrap.
  - The re-evaluated hit after a refill does not count as a hit.
- Reset (`rst_ni` = 0) clears, immediately and asynchronously:
  - all valid, dirty and PLRU bits;
  - the FSM (to IDLE);
  - both counters.
  - `mem_req_o` drops in the same cycle. A request in flight is abandoned and a late ack is ignored.
  - The tag and data arrays are not reset.
- `WAYS` = 1: no PLRU bits; the victim is always way 0.

## Timing
- Reset values: `data_o` = 0, `stall_o` = 0, `mem_req_o` = 0, `mem_we_o` = 0, `mem_addr_o` = 0, `mem_wdata_o` = 0, counters = 0.
- Hit: 0-cycle latency. `data_o` is combinational; array and PLRU updates occur on the next rising edge.
- Clean miss with ack in the first REFILL cycle: `stall_o` is high for 2 cycles (the IDLE miss cycle plus REFILL).
- Dirty miss, with ack in the first cycle of each of WB and REFILL: `stall_o` high for 3 cycles.
- Each extra ack wait cycle adds 1 stall cycle.
- `mem_ack_i` is sampled only while `mem_req_o` = 1.
- The pipeline must hold `addr_i`, `data_i`, `be_i` and the request signals stable while `stall_o` = 1.
- `mem_*` outputs are registered from state; `stall_o` is combinational.

## Structure
- Shared package `dcache_pkg`:
  - `dcache_state_e` (IDLE, WB, REFILL);
  - line struct typedef;
  - `WAYS_MAX` = 4;
  - PLRU update and victim functions.
- Sub-module `plru_tree`, parametrised by WAYS:
  - inputs: PLRU bits, access way;
  - outputs: next PLRU bits, victim way;
  - purely combinational.
- The top level holds the arrays, hit detection, FSM and counters.

## Test plan
- Reset, then load 0x0000_0100 → miss, `stall_o` = 1, REFILL reads 0x100. Ack with 0xDEADBEEF → next cycle `data_o` = 0xDEADBEEF, `stall_o` = 0. Counters: miss 1, hit 0.
- Store 0x11223344 with `be_i` = 4'b0011 to a resident line holding 0xAABBCCDD → zero stall; a subsequent load returns 0xAABB3344; the line is dirty.
- `WAYS` = 2: fill set 0 with tags A and B (both dirty), touch A, then access tag C → WB to B's address with B's data, then REFILL for C. Total 3 stall cycles with immediate acks.
- Ack delayed 4 cycles during REFILL → `mem_req_o` and `mem_addr_o` stay stable; `stall_o` is high for 6 cycles.
- Deassert `rst_ni` mid-REFILL, with ack arriving the same cycle → `mem_req_o` = 0 immediately, no line valid, counters = 0. The next load to the same address misses.
- Force `miss_count_o` to all-ones (`CNT_WIDTH` = 4, 16 misses) → it stays at 15 on the next miss.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared definitions for the set-associative write-back data cache.
//   dcache_state_e : miss-handling FSM states
//   line_meta_t    : per-line status bits (tag and data live in separate,
//                    unreset arrays in the top level)
//   WAYS_MAX       : largest supported associativity
//   plru_victim4 / plru_update4 : 3-bit tree pseudo-LRU helpers for 4 ways
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WB     = 2'd1,
    REFILL = 2'd2
  } dcache_state_e;

  typedef struct packed {
    logic valid;
    logic dirty;
  } line_meta_t;

  localparam int WAYS_MAX = 4;

  // Tree layout: bit0 = root, bit1 = pair {0,1}, bit2 = pair {2,3}.
  // A bit value of 0 points at the lower half / lower way.
  function automatic logic [1:0] plru_victim4(input logic [WAYS_MAX-2:0] bits);
    return bits[0] ? {1'b1, bits[2]} : {1'b0, bits[1]};
  endfunction

  // Flip the path bits so they point away from the accessed way.
  function automatic logic [WAYS_MAX-2:0] plru_update4(input logic [WAYS_MAX-2:0] bits,
                                                        input logic [1:0]          way);
    logic [WAYS_MAX-2:0] nb;
    nb    = bits;
    nb[0] = ~way[1];
    if (way[1]) nb[2] = ~way[0];
    else        nb[1] = ~way[0];
    return nb;
  endfunction

endpackage

// File: rtl/dcache_sa_wb_plru.sv
// Combinational tree pseudo-LRU for one cache set.
//   plru_i       : current PLRU bits of the set
//   access_way_i : way being accessed (hit way)
//   plru_o       : PLRU bits after recording the access
//   victim_o     : way the current bits point at
module plru_tree
  import dcache_pkg::*;
#(
  parameter  int WAYS = 2,
  localparam int PB   = (WAYS > 1) ? WAYS - 1 : 1,
  localparam int WW   = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [PB-1:0] plru_i,
  input  logic [WW-1:0] access_way_i,
  output logic [PB-1:0] plru_o,
  output logic [WW-1:0] victim_o
);

  if (WAYS == 4) begin : g_four
    assign plru_o   = plru_update4(plru_i, access_way_i);
    assign victim_o = plru_victim4(plru_i);
  end else if (WAYS == 2) begin : g_two
    assign plru_o   = ~access_way_i;
    assign victim_o = plru_i;
  end else begin : g_one
    // Direct-mapped: no replacement state, way 0 is always the victim.
    logic unused_way;
    assign unused_way = ^access_way_i;
    assign plru_o     = plru_i;
    assign victim_o   = '0;
  end

endmodule

// File: rtl/dcache_sa_wb.sv
// N-way set-associative, write-back, write-allocate data cache (one word
// per line) for the MEM stage. Hits complete combinationally; misses stall
// the pipeline while an FSM writes back a dirty victim and refills the line.
//   MemWriteM_i/ResultSrcM_i/be_i/addr_i/data_i : pipeline access
//   data_o, stall_o                             : load data, pipeline hold
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o   : registered memory request
//   mem_rdata_i/mem_ack_i                       : memory response
//   hit_count_o/miss_count_o                    : saturating perf counters
module dcache_sa_wb
  import dcache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int SET_BITS      = 8,
  parameter int WAYS          = 2,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    MemWriteM_i,
  input  logic [1:0]              ResultSrcM_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [ADDRESS_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0]   data_i,
  output logic [DATA_WIDTH-1:0]   data_o,
  output logic                    stall_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic                    mem_ack_i,
  output logic [CNT_WIDTH-1:0]    hit_count_o,
  output logic [CNT_WIDTH-1:0]    miss_count_o
);

  localparam int TAG_W = ADDRESS_WIDTH - SET_BITS - 2;
  localparam int SETS  = 1 << SET_BITS;
  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int WW    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int PB    = (WAYS > 1) ? WAYS - 1 : 1;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_WB     = WB;
  localparam logic [1:0] ST_REFILL = REFILL;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] be_merge(input logic [DATA_WIDTH-1:0] old_d,
                                                     input logic [DATA_WIDTH-1:0] new_d,
                                                     input logic [BE_W-1:0]       be);
    logic [DATA_WIDTH-1:0] r;
    r = old_d;
    for (int b = 0; b < BE_W; b++) begin
      if (be[b]) r[8*b +: 8] = new_d[8*b +: 8];
    end
    return r;
  endfunction

  // Status bits and PLRU are reset; tag/data arrays are not.
  line_meta_t            meta_q [SETS][WAYS];
  logic [TAG_W-1:0]      tag_q  [SETS][WAYS];
  logic [DATA_WIDTH-1:0] data_q [SETS][WAYS];
  logic [PB-1:0]         plru_q [SETS];

  logic [1:0]              state_q, state_d;
  logic [WW-1:0]           victim_q, victim_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic                    refilled_q, refilled_d;
  logic [CNT_WIDTH-1:0]    hit_cnt_q, hit_cnt_d;
  logic [CNT_WIDTH-1:0]    miss_cnt_q, miss_cnt_d;

  logic [SET_BITS-1:0] set_idx;
  logic [TAG_W-1:0]    tag_in;
  logic                unused_addr;
  logic                is_store, is_load, access, hit, any_inv, ack_v;
  logic [WAYS-1:0]     hit_vec;
  logic [WW-1:0]       hit_way, inv_way, plru_victim, victim_way;
  logic [PB-1:0]       plru_next;
  logic                hit_wr, fill_wr;

  assign set_idx     = addr_i[SET_BITS+1:2];
  assign tag_in      = addr_i[ADDRESS_WIDTH-1:SET_BITS+2];
  assign unused_addr = ^addr_i[1:0];

  assign is_store = MemWriteM_i;
  assign is_load  = !MemWriteM_i && (ResultSrcM_i == 2'b01);
  assign access   = is_store || is_load;
  assign ack_v    = mem_ack_i && mem_req_q;

  always_comb begin
    hit_vec = '0;
    hit_way = '0;
    inv_way = '0;
    any_inv = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = meta_q[set_idx][w].valid && (tag_q[set_idx][w] == tag_in);
      if (hit_vec[w]) hit_way = WW'(w);
    end
    // Descending scan so the lowest-index invalid way wins.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!meta_q[set_idx][w].valid) begin
        inv_way = WW'(w);
        any_inv = 1'b1;
      end
    end
  end

  assign hit        = access && (|hit_vec);
  assign victim_way = any_inv ? inv_way : plru_victim;

  plru_tree #(.WAYS(WAYS)) u_plru (
    .plru_i       (plru_q[set_idx]),
    .access_way_i (hit_way),
    .plru_o       (plru_next),
    .victim_o     (plru_victim)
  );

  always_comb begin
    state_d     = state_q;
    victim_d    = victim_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    refilled_d  = 1'b0;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    hit_wr      = 1'b0;
    fill_wr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (access && !hit) begin
          victim_d   = victim_way;
          miss_cnt_d = sat_inc(miss_cnt_q);
          mem_req_d  = 1'b1;
          if (meta_q[set_idx][victim_way].valid && meta_q[set_idx][victim_way].dirty) begin
            state_d     = ST_WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = {tag_q[set_idx][victim_way], set_idx, 2'b00};
            mem_wdata_d = data_q[set_idx][victim_way];
          end else begin
            state_d    = ST_REFILL;
            mem_we_d   = 1'b0;
            mem_addr_d = {tag_in, set_idx, 2'b00};
          end
        end else if (hit) begin
          hit_wr = 1'b1;
          // The replayed access right after a refill was already counted as a miss.
          if (!refilled_q) hit_cnt_d = sat_inc(hit_cnt_q);
        end
      end
      ST_WB: begin
        if (ack_v) begin
          state_d    = ST_REFILL;
          mem_we_d   = 1'b0;
          mem_addr_d = {tag_in, set_idx, 2'b00};
        end
      end
      ST_REFILL: begin
        if (ack_v) begin
          state_d    = ST_IDLE;
          mem_req_d  = 1'b0;
          fill_wr    = 1'b1;
          refilled_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stall_o      = (state_q != ST_IDLE) || (access && !hit);
  assign data_o       = ((state_q == ST_IDLE) && is_load && hit) ? data_q[set_idx][hit_way] : '0;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign hit_count_o  = hit_cnt_q;
  assign miss_count_o = miss_cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      victim_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      refilled_q  <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      victim_q    <= victim_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      refilled_q  <= refilled_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) meta_q[s][w] <= '0;
      end
    end else begin
      if (hit_wr) begin
        if (is_store) meta_q[set_idx][hit_way].dirty <= 1'b1;
        if (WAYS > 1) plru_q[set_idx] <= plru_next;
      end
      if (fill_wr) meta_q[set_idx][victim_q] <= '{valid: 1'b1, dirty: 1'b0};
    end
  end

  always_ff @(posedge clk_i) begin
    if (hit_wr && is_store) data_q[set_idx][hit_way] <= be_merge(data_q[set_idx][hit_way], data_i, be_i);
    if (fill_wr) begin
      tag_q[set_idx][victim_q]  <= tag_in;
      data_q[set_idx][victim_q] <= mem_rdata_i;
    end
  end

endmodule

// File: tb/tb_dcache_sa_wb.sv
module tb_dcache_sa_wb;

  localparam int LIMIT = 40;

  logic        clk;
  logic        rst_n;
  logic        mem_write;
  logic [1:0]  result_src;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] data_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [3:0]  hit_cnt;
  logic [3:0]  miss_cnt;

  logic        resp_en;
  logic        ack_auto, ack_man;
  logic [31:0] rdata_auto, rdata_man;
  int          ack_delay;
  logic        mon_en;
  logic [31:0] mon_addr;

  assign mem_ack   = resp_en ? ack_auto : ack_man;
  assign mem_rdata = resp_en ? rdata_auto : rdata_man;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;
  txn_t txn_log[$];

  typedef struct {
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_d;
    int          exp_s;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    int          s;
  } exp_t;
  exp_t exp_q[$];

  int total = 0;
  int bad   = 0;

  dcache_sa_wb #(
    .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SET_BITS(8), .WAYS(2), .CNT_WIDTH(4)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .MemWriteM_i  (mem_write),
    .ResultSrcM_i (result_src),
    .be_i         (be),
    .addr_i       (addr),
    .data_i       (wdata),
    .data_o       (data_o),
    .stall_o      (stall_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_rdata_i  (mem_rdata),
    .mem_ack_i    (mem_ack),
    .hit_count_o  (hit_cnt),
    .miss_count_o (miss_cnt)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_default(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory model: acks each request after ack_delay wait cycles.
  logic [31:0] mem [logic [31:0]];
  initial begin
    int wait_cnt;
    wait_cnt   = 0;
    ack_auto   = 0;
    rdata_auto = 0;
    mem[32'h100] = 32'hDEAD_BEEF;
    mem[32'h200] = 32'hAABB_CCDD;
    mem[32'h400] = 32'hA0A0_A0A0;
    mem[32'h800] = 32'hB0B0_B0B0;
    mem[32'hC00] = 32'hC0C0_C0C0;
    mem[32'h600] = 32'h6666_6666;
    mem[32'hA00] = 32'hAAAA_0000;
    forever begin
      @(negedge clk);
      if (resp_en) begin
        ack_auto = 0;
        if (mem_req_o) begin
          if (wait_cnt >= ack_delay) begin
            ack_auto = 1;
            wait_cnt = 0;
            if (mem_we_o) begin
              mem[mem_addr_o] = mem_wdata_o;
              txn_log.push_back('{1'b1, mem_addr_o, mem_wdata_o});
            end else begin
              rdata_auto = mem.exists(mem_addr_o) ? mem[mem_addr_o] : mem_default(mem_addr_o);
              txn_log.push_back('{1'b0, mem_addr_o, 32'h0});
            end
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    mem_write  = st;
    result_src = st ? 2'b00 : 2'b01;
    addr       = a;
    wdata      = d;
    be         = b;
  endtask

  task automatic do_reset();
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    result_src = 2'b00;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  // Called mid-cycle with an access driven; returns load data and stall cycles.
  task automatic finish_access(output logic [31:0] rd, output int st);
    st = 0;
    while (stall_o && st < LIMIT) begin
      st++;
      if (mon_en && st > 1) chk("req_hold", {mem_req_o, mem_addr_o}, {1'b1, mon_addr});
      @(negedge clk);
      #1;
    end
    if (stall_o) begin
      total++;
      bad++;
      $display("FAIL timeout: stall_o still 1 after %0d cycles, expected 0", st);
    end
    rd = data_o;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_access(input logic st, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] b, output logic [31:0] rd, output int s);
    drive(st, a, d, b);
    #1;
    finish_access(rd, s);
  endtask

  vec_t        vec [13];
  txn_t        exp_txn [12];
  logic [31:0] got_d;
  int          got_s;
  exp_t        e;

  initial begin
    vec[0]  = '{1'b0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, 2};
    vec[1]  = '{1'b0, 32'h100, 32'h0,         4'h0, 32'hDEAD_BEEF, 0};
    vec[2]  = '{1'b0, 32'h200, 32'h0,         4'h0, 32'hAABB_CCDD, 2};
    vec[3]  = '{1'b1, 32'h200, 32'h1122_3344, 4'h3, 32'h0,         0};
    vec[4]  = '{1'b0, 32'h200, 32'h0,         4'h0, 32'hAABB_3344, 0};
    vec[5]  = '{1'b1, 32'h400, 32'h1234_5678, 4'hF, 32'h0,         2};
    vec[6]  = '{1'b1, 32'h800, 32'h8765_4321, 4'hF, 32'h0,         2};
    vec[7]  = '{1'b0, 32'h400, 32'h0,         4'h0, 32'h1234_5678, 0};
    vec[8]  = '{1'b0, 32'hC00, 32'h0,         4'h0, 32'hC0C0_C0C0, 3};
    vec[9]  = '{1'b0, 32'h800, 32'h0,         4'h0, 32'h8765_4321, 3};
    vec[10] = '{1'b0, 32'h400, 32'h0,         4'h0, 32'h1234_5678, 2};
    vec[11] = '{1'b0, 32'h600, 32'h0,         4'h0, 32'h6666_6666, 2};
    vec[12] = '{1'b0, 32'hA00, 32'h0,         4'h0, 32'hAAAA_0000, 3};

    exp_txn[0]  = '{1'b0, 32'h100, 32'h0};
    exp_txn[1]  = '{1'b0, 32'h200, 32'h0};
    exp_txn[2]  = '{1'b0, 32'h400, 32'h0};
    exp_txn[3]  = '{1'b0, 32'h800, 32'h0};
    exp_txn[4]  = '{1'b1, 32'h800, 32'h8765_4321};
    exp_txn[5]  = '{1'b0, 32'hC00, 32'h0};
    exp_txn[6]  = '{1'b1, 32'h400, 32'h1234_5678};
    exp_txn[7]  = '{1'b0, 32'h800, 32'h0};
    exp_txn[8]  = '{1'b0, 32'h400, 32'h0};
    exp_txn[9]  = '{1'b0, 32'h600, 32'h0};
    exp_txn[10] = '{1'b1, 32'h200, 32'hAABB_3344};
    exp_txn[11] = '{1'b0, 32'hA00, 32'h0};

    resp_en   = 1;
    ack_man   = 0;
    rdata_man = 0;
    ack_delay = 0;
    mon_en    = 0;
    mon_addr  = 0;

    // Reset state.
    do_reset();
    #1;
    chk("rst data_o", data_o, 0);
    chk("rst stall", stall_o, 0);
    chk("rst mem_req/we", {mem_req_o, mem_we_o}, 0);
    chk("rst mem_addr", mem_addr_o, 0);
    chk("rst mem_wdata", mem_wdata_o, 0);
    chk("rst counters", {hit_cnt, miss_cnt}, 0);
    @(negedge clk);

    // Table-driven accesses with immediate acks.
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back('{vec[i].exp_d, vec[i].exp_s});
      do_access(vec[i].st, vec[i].addr, vec[i].wdata, vec[i].be, got_d, got_s);
      e = exp_q.pop_front();
      chk($sformatf("v%0d data", i), got_d, e.d);
      chk($sformatf("v%0d stalls", i), got_s, e.s);
      if (i == 0) chk("first miss counters", {hit_cnt, miss_cnt}, {4'd0, 4'd1});
    end
    drive(1'b0, 32'h0, 32'h0, 4'h0);
    result_src = 2'b00;
    chk("table hit_count", hit_cnt, 4);
    chk("table miss_count", miss_cnt, 9);
    chk("txn count", txn_log.size(), 12);
    for (int i = 0; i < 12 && i < txn_log.size(); i++)
      chk($sformatf("txn%0d", i), {txn_log[i].we, txn_log[i].addr, txn_log[i].data},
          {exp_txn[i].we, exp_txn[i].addr, exp_txn[i].data});

    // Refill ack delayed by 4 cycles: request held stable, 6 stall cycles.
    do_reset();
    ack_delay = 4;
    mon_en    = 1;
    mon_addr  = 32'h100;
    do_access(1'b0, 32'h100, 32'h0, 4'h0, got_d, got_s);
    mon_en    = 0;
    ack_delay = 0;
    chk("delay data", got_d, 32'hDEAD_BEEF);
    chk("delay stalls", got_s, 6);

    // Reset mid-REFILL with an ack arriving in the same cycle.
    do_reset();
    resp_en = 0;
    drive(1'b0, 32'h100, 32'h0, 4'h0);
    #1;
    chk("rst_t miss stall", stall_o, 1);
    @(negedge clk);
    #1;
    chk("rst_t refill req", {mem_req_o, mem_we_o, mem_addr_o}, {1'b1, 1'b0, 32'h100});
    ack_man   = 1;
    rdata_man = 32'h9999_9999;
    rst_n     = 0;
    #1;
    chk("rst_t req drop", mem_req_o, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1;
    ack_man = 0;
    #1;
    chk("rst_t counters", {hit_cnt, miss_cnt}, 0);
    chk("rst_t still miss", stall_o, 1);
    chk("rst_t data_o", data_o, 0);
    resp_en = 1;
    finish_access(got_d, got_s);
    chk("rst_t reload data", got_d, 32'hDEAD_BEEF);
    chk("rst_t reload stalls", got_s, 2);
    chk("rst_t miss_count", miss_cnt, 1);

    // Miss counter saturation.
    do_reset();
    for (int i = 0; i < 15; i++)
      do_access(1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, got_d, got_s);
    chk("sat data", got_d, mem_default(32'h1000 + 32'd56));
    chk("sat miss at 15", miss_cnt, 15);
    for (int i = 15; i < 17; i++)
      do_access(1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0, got_d, got_s);
    chk("sat miss held", miss_cnt, 15);
    chk("sat hit_count", hit_cnt, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
